level_fifo: RTL



---
 rtl/level_fifo.sv | 113 +++++++++++
 1 files changed

// File: rtl/level_fifo.sv
// Synchronous FIFO with FWFT or registered-read output, programmable almost-full/empty
// thresholds, occupancy count and synchronous flush. Define FIFO_ERR_FLAGS_EN for sticky overflow/underflow flags.
module level_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int AF_TH = 6,
  parameter int AE_TH = 2,
  parameter int FWFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         write_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         read_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     almost_full_o,
  output logic                     almost_empty_o,
  output logic [$clog2(DEPTH):0]   count_o
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                     overflow_o,
  output logic                     underflow_o,
  input  logic                     err_clr_i
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_TH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_TH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  // Flags come straight from the registered count, so acceptance uses the pre-edge state.
  assign full_o         = (count_o == DEPTH_C);
  assign empty_o        = (count_o == {CW{1'b0}});
  assign almost_full_o  = (count_o >= AF_C);
  assign almost_empty_o = (count_o <= AE_C);
  assign wr_acc         = wr_en_i && !full_o && !flush_i;
  assign rd_acc         = rd_en_i && !empty_o && !flush_i;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= write_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= {AW{1'b0}};
      rd_ptr  <= {AW{1'b0}};
      count_o <= {CW{1'b0}};
    end else if (flush_i) begin
      wr_ptr  <= {AW{1'b0}};
      rd_ptr  <= {AW{1'b0}};
      count_o <= {CW{1'b0}};
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count_o <= count_o + CW'(1);
        2'b01:   count_o <= count_o - CW'(1);
        default: count_o <= count_o;
      endcase
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry falls through; zero while empty so stale storage never leaks out.
      assign read_data_o = empty_o ? {WIDTH{1'b0}} : mem[rd_ptr];
    end else begin : g_reg
      logic [WIDTH-1:0] rd_data;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data <= {WIDTH{1'b0}};
        end else if (flush_i) begin
          rd_data <= {WIDTH{1'b0}};
        end else if (rd_acc) begin
          rd_data <= mem[rd_ptr];
        end else begin
          rd_data <= rd_data;
        end
      end
      assign read_data_o = rd_data;
    end
  endgenerate

`ifdef FIFO_ERR_FLAGS_EN
  // Clear beats a same-cycle set; an attempted write while full counts even if a read frees space.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (err_clr_i || flush_i) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wr_en_i && full_o)  overflow_o  <= 1'b1;
      if (rd_en_i && empty_o) underflow_o <= 1'b1;
    end
  end
`endif

endmodule
